seg_scan_mux: RTL and testbench

Time-multiplexed scanner for a common-anode multi-digit 7-segment display. Holds a multi-digit hex value and selects one digit per refresh slot. Feeds the current 4-bit nibble to binary_to_disp (downstream) and drives the digit anodes and decimal point.
Value updates are deferred to frame boundaries, so a half-old/half-new value is never shown.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_refresh_prescaler.sv | 38 +++
 rtl/seg_scan_mux.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_mux.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner.
package seg_pkg;

  localparam int   NIBBLE_W           = 4;
  localparam int   DEFAULT_NUM_DIGITS = 4;

  // Anodes and decimal point are active-low, so "off" is a 1.
  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_OFF    = 1'b1;

  // True when a 4-bit digit is zero; used for leading-zero blanking.
  function automatic logic nibble_is_zero(input logic [NIBBLE_W-1:0] nib);
    return (nib == 4'h0);
  endfunction

endpackage

// File: rtl/seg_refresh_prescaler.sv
// Slot timer: counts 0..REFRESH_DIV-1, flags the last cycle of a slot
// (tick) and whether the anti-ghosting guard window has elapsed (lit).
module seg_refresh_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 8
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic lit
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-count logic and slot flags derived from the current count.
  always_comb begin
    tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    lit  = (cnt_q >= CNT_W'(GUARD));
    if (tick) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Slot counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner. One digit per refresh
// slot; new values are only adopted at the frame boundary so a frame never
// mixes old and new digits.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  input  logic                           load,
  output logic                           update_pending,
  output logic [NIBBLE_W-1:0]            binary,
  output logic                           dp_out,
  output logic [NUM_DIGITS-1:0]          anode,
  output logic                           frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

  logic tick;
  logic lit;

  logic [IDX_W-1:0]      idx_q,          idx_d;
  logic [VAL_W-1:0]      shown_q,        shown_d;
  logic [NUM_DIGITS-1:0] shown_dp_q,     shown_dp_d;
  logic [VAL_W-1:0]      pending_q,      pending_d;
  logic [NUM_DIGITS-1:0] pending_dp_q,   pending_dp_d;
  logic                  upd_q,          upd_d;
  logic [NUM_DIGITS-1:0] anode_q,        anode_d;
  logic [NIBBLE_W-1:0]   binary_q,       binary_d;
  logic                  dp_q,           dp_d;
  logic                  frame_start_q,  frame_start_d;

  logic                  last_slot;
  logic                  frame_tick;
  logic [NUM_DIGITS-1:0] blank;
  logic [NIBBLE_W-1:0]   shown_nib [NUM_DIGITS];

  seg_refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .lit  (lit)
  );

  // Split the shown value into per-digit nibbles for indexed selection.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shown_nib[i] = shown_q[i*NIBBLE_W +: NIBBLE_W];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every more-significant digit are zero and its
  // dp is off; digit 0 always stays visible so zero reads as "0".
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & nibble_is_zero(shown_nib[i]);
      if (i != 0) begin
        blank[i] = zero_above & ~shown_dp_q[i];
      end else begin
        blank[i] = 1'b0;
      end
    end
  end
`else
  // All digits are always displayed.
  always_comb begin
    blank = {NUM_DIGITS{1'b0}};
  end
`endif

  // Digit sequencing, load handshake and frame-boundary transfer.
  always_comb begin
    last_slot  = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_tick = tick & last_slot;

    if (tick) begin
      if (last_slot) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    shown_d      = shown_q;
    shown_dp_d   = shown_dp_q;
    pending_d    = pending_q;
    pending_dp_d = pending_dp_q;
    upd_d        = upd_q;
    if (frame_tick) begin
      // A load on the boundary bypasses the pending register.
      if (load) begin
        shown_d    = value;
        shown_dp_d = dp_in;
        upd_d      = 1'b0;
      end else if (upd_q) begin
        shown_d    = pending_q;
        shown_dp_d = pending_dp_q;
        upd_d      = 1'b0;
      end else begin
        upd_d      = 1'b0;
      end
    end else if (load) begin
      // Last load before the boundary wins.
      pending_d    = value;
      pending_dp_d = dp_in;
      upd_d        = 1'b1;
    end else begin
      upd_d        = upd_q;
    end

    frame_start_d = frame_tick;
  end

  // Display outputs for the current slot, one cycle behind the slot state.
  always_comb begin
    anode_d  = {NUM_DIGITS{ANODE_OFF}};
    binary_d = shown_nib[idx_q];
    dp_d     = ~shown_dp_q[idx_q];
    if (lit && !blank[idx_q]) begin
      anode_d[idx_q] = ~ANODE_OFF;
    end else begin
      anode_d = {NUM_DIGITS{ANODE_OFF}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= {IDX_W{1'b0}};
      shown_q       <= {VAL_W{1'b0}};
      shown_dp_q    <= {NUM_DIGITS{1'b0}};
      pending_q     <= {VAL_W{1'b0}};
      pending_dp_q  <= {NUM_DIGITS{1'b0}};
      upd_q         <= 1'b0;
      anode_q       <= {NUM_DIGITS{ANODE_OFF}};
      binary_q      <= {NIBBLE_W{1'b0}};
      dp_q          <= DP_OFF;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shown_q       <= shown_d;
      shown_dp_q    <= shown_dp_d;
      pending_q     <= pending_d;
      pending_dp_q  <= pending_dp_d;
      upd_q         <= upd_d;
      anode_q       <= anode_d;
      binary_q      <= binary_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign update_pending = upd_q;
  assign anode          = anode_q;
  assign binary         = binary_q;
  assign dp_out         = dp_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (NUM_DIGITS=4, REFRESH_DIV=6, GUARD=2).
// A cycle-count based reference model is compared on every clock.
module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int DIV   = 6;
  localparam int GRD   = 2;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          load;
  logic          update_pending;
  logic [3:0]    binary;
  logic          dp_out;
  logic [3:0]    anode;
  logic          frame_start;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: k = clock edges since reset release.
  int          k;
  logic [15:0] m_shown, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_upd;

  seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk            (clk),
    .rst            (rst),
    .value          (value),
    .dp_in          (dp_in),
    .load           (load),
    .update_pending (update_pending),
    .binary         (binary),
    .dp_out         (dp_out),
    .anode          (anode),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic logic model_blank(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < N; j++) begin
      if (((m_shown >> (4 * j)) & 16'h000F) != 16'h0000) return 1'b0;
    end
    return (m_sdp[d] == 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: predict outputs from the model, advance the model, compare.
  task automatic step();
    logic [3:0] e_anode, e_bin;
    logic       e_dp, e_fs;
    int         slot, phase;
    if (rst) begin
      e_anode = 4'b1111; e_bin = 4'h0; e_dp = 1'b1; e_fs = 1'b0;
      k = 0; m_shown = 16'h0; m_sdp = 4'h0; m_pend = 16'h0; m_pdp = 4'h0; m_upd = 1'b0;
    end else begin
      slot  = (k / DIV) % N;
      phase = k % DIV;
      e_anode = 4'b1111;
      if (phase >= GRD && !model_blank(slot)) e_anode[slot] = 1'b0;
      e_bin = 4'((m_shown >> (4 * slot)) & 16'h000F);
      e_dp  = ~m_sdp[slot];
      e_fs  = ((k % FRAME) == FRAME - 1);
      if (e_fs) begin
        if (load) begin
          m_shown = value; m_sdp = dp_in; m_upd = 1'b0;
        end else if (m_upd) begin
          m_shown = m_pend; m_sdp = m_pdp; m_upd = 1'b0;
        end
      end else if (load) begin
        m_pend = value; m_pdp = dp_in; m_upd = 1'b1;
      end
      k++;
    end
    @(posedge clk);
    #1;
    check("anode", 32'(anode), 32'(e_anode));
    check("binary", 32'(binary), 32'(e_bin));
    check("dp_out", 32'(dp_out), 32'(e_dp));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("update_pending", 32'(update_pending), 32'(m_upd));
    check("one_anode_low", 32'($countones(~anode) <= 1), 32'd1);
  endtask

  // Step until a frame_start pulse is seen, bounded.
  task automatic wait_fs();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      step();
      seen = frame_start;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_fs: got timeout expected frame_start pulse (k=%0d)", k);
    end
  endtask

  // Step until the model position within the frame reaches pos, bounded.
  task automatic wait_pos(input int pos);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != pos; i++) step();
  endtask

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [15:0] exp_bin;
    logic [3:0]  exp_dpo;
  } vec_t;

  vec_t       vecs [4];
  logic [3:0] exp_an [4];
  int         gap;

  initial begin
    vecs[0] = '{16'h1A2F, 4'b0100, 16'h1A2F, 4'b1011};
    vecs[1] = '{16'h8B3C, 4'b1001, 16'h8B3C, 4'b0110};
    vecs[2] = '{16'hFFFF, 4'b1111, 16'hFFFF, 4'b0000};
    vecs[3] = '{16'h1000, 4'b0000, 16'h1000, 4'b1111};
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;

    // Reset and release with value 0.
    rst = 1'b1; load = 1'b0; value = 16'h0000; dp_in = 4'h0;
    repeat (3) step();
    check("rst_anode", 32'(anode), 32'h0000000F);
    check("rst_dp_out", 32'(dp_out), 32'd1);
    rst = 1'b0;
    step(); step();
    check("guard_anode", 32'(anode), 32'h0000000F);
    step();
    check("first_lit_anode", 32'(anode), 32'h0000000E);

    // Table-driven: load, then verify each digit slot of the next frame.
    for (int v = 0; v < 4; v++) begin
      value = vecs[v].value; dp_in = vecs[v].dp; load = 1'b1;
      step();
      load = 1'b0;
      check("tbl_pending", 32'(update_pending), 32'd1);
      wait_fs();
      step(); step(); step();
      for (int d = 0; d < N; d++) begin
        check("tbl_anode", 32'(anode), 32'(exp_an[d]));
        check("tbl_binary", 32'(binary), 32'(vecs[v].exp_bin[d*4 +: 4]));
        check("tbl_dp_out", 32'(dp_out), 32'(vecs[v].exp_dpo[d]));
        repeat (DIV) step();
      end
    end

    // frame_start period.
    wait_fs();
    gap = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      gap++;
      if (frame_start) break;
    end
    check("frame_period", 32'(gap), 32'(FRAME));

    // Two loads in one frame: last wins, shown unchanged until the wrap.
    wait_pos(5);
    value = 16'h1111; load = 1'b1; step(); load = 1'b0;
    step(); step();
    value = 16'h2222; load = 1'b1; step(); load = 1'b0;
    check("double_pending", 32'(update_pending), 32'd1);
    wait_fs();
    step(); step(); step();
    check("double_binary", 32'(binary), 32'h2);

    // Load coincident with the final-slot tick goes straight to shown.
    wait_pos(FRAME - 1);
    value = 16'h3C3C; dp_in = 4'b0000; load = 1'b1; step(); load = 1'b0;
    check("coinc_fs", 32'(frame_start), 32'd1);
    check("coinc_pending", 32'(update_pending), 32'd0);
    step(); step(); step();
    check("coinc_binary", 32'(binary), 32'hC);

    // Randomized loads against the model.
    for (int i = 0; i < 400; i++) begin
      value = 16'($urandom);
      dp_in = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      step();
    end
    load = 1'b0;

    // Reset mid-slot with a pending update.
    value = 16'h9999; load = 1'b1; step(); load = 1'b0;
    wait_pos(16);
    rst = 1'b1; step();
    check("midrst_anode", 32'(anode), 32'h0000000F);
    check("midrst_pending", 32'(update_pending), 32'd0);
    rst = 1'b0;
    step(); step(); step();
    check("midrst_digit0", 32'(anode), 32'h0000000E);
    check("midrst_binary", 32'(binary), 32'h0);

`ifdef LEADING_ZERO_BLANK_EN
    value = 16'h0070; dp_in = 4'b0000; load = 1'b1; step(); load = 1'b0;
    wait_fs();
    step(); step(); step();
    check("blank_d0", 32'(anode), 32'h0000000E); repeat (DIV) step();
    check("blank_d1", 32'(anode), 32'h0000000D); repeat (DIV) step();
    check("blank_d2", 32'(anode), 32'h0000000F); repeat (DIV) step();
    check("blank_d3", 32'(anode), 32'h0000000F);
    value = 16'h0000; load = 1'b1; step(); load = 1'b0;
    wait_fs();
    step(); step(); step();
    check("zero_d0", 32'(anode), 32'h0000000E);
    check("zero_bin", 32'(binary), 32'h0);
    repeat (DIV) step();
    check("zero_d1", 32'(anode), 32'h0000000F);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
